cmi_tx_ctrl: RTL and testbench

CMI_TX_CTRL -- requirements
Module: cmi_tx_ctrl

---
 rtl/cmi_pkg.sv | 18 +
 rtl/cmi_rr_arb2.sv | 8 +
 rtl/cmi_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_cmi_tx_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cmi_pkg.sv
// cmi_pkg: shared state type, default sync pattern and counter sizing for cmi_tx_ctrl.
// ST_PARITY exists only when CMI_TX_PARITY_EN is defined.
package cmi_pkg;
   localparam logic [7:0] CMI_SYNC_WORD = 8'hE4;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
`ifdef CMI_TX_PARITY_EN
      ST_DATA,
      ST_PARITY
`else
      ST_DATA
`endif
   } cmi_state_e;
   function automatic int cmi_cnt_w(input int data_w);
      return $clog2(data_w > 8 ? data_w : 8);
   endfunction
endpackage

// File: rtl/cmi_rr_arb2.sv
// cmi_rr_arb2: two-requester round-robin arbiter; pointer is the requester favoured on a tie.
module cmi_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       pointer,
   output logic [1:0] grant
);
   assign grant = {valid[1] & (~valid[0] | pointer), valid[0] & (~valid[1] | ~pointer)};
endmodule

// File: rtl/cmi_tx_ctrl.sv
// cmi_tx_ctrl: frames arbitrated payloads as sync word + data bits for a CMI encoder.
// Define CMI_TX_PARITY_EN to append an even-parity bit after the payload.
module cmi_tx_ctrl
   import cmi_pkg::*;
#(
   parameter logic [7:0] SYNC_WORD = CMI_SYNC_WORD,
   parameter int         DATA_W    = 8
) (
   input  logic              clk_sig,
   input  logic              reset_sig,
   input  logic [1:0]        req_valid,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic [1:0]        req_ready,
   output logic              q_sig,
   output logic              enc_reset_sig,
   output logic              busy,
   output logic              grant_id,
   output logic              frame_done
);
   localparam int CW = cmi_cnt_w(DATA_W);
   localparam int FW = DATA_W + 7;
   localparam logic [CW-1:0] SYNC_LAST = CW'(7);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
`ifdef CMI_TX_PARITY_EN
   localparam logic [CW-1:0] DONE_AT = DATA_LAST;
`else
   localparam logic [CW-1:0] DONE_AT = CW'(DATA_W - 2);
`endif
   cmi_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [FW-1:0]     fr_q, fr_d;
   logic              q_q, q_d, done_q, done_d, grant_q, grant_d, ptr_q, ptr_d;
   logic [1:0]        gnt;
   logic [DATA_W-1:0] pay;
   logic              xfer;
`ifdef CMI_TX_PARITY_EN
   logic              par_q, par_d;
`endif
   cmi_rr_arb2 u_arb (
      .valid  (req_valid),
      .pointer(ptr_q),
      .grant  (gnt)
   );
   assign req_ready     = (state_q == ST_IDLE && reset_sig) ? gnt : 2'b00;
   assign xfer          = |req_ready;
   assign pay           = gnt[1] ? req_data1 : req_data0;
   assign q_sig         = q_q;
   assign busy          = state_q != ST_IDLE;
   assign enc_reset_sig = state_q != ST_IDLE;
   assign grant_id      = grant_q;
   assign frame_done    = done_q;
   // q_q is registered, so each cycle computes the bit shown in the next one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      fr_d    = fr_q << 1;
      q_d     = fr_q[FW-1];
      done_d  = 1'b0;
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef CMI_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            fr_d  = fr_q;
            q_d   = 1'b0;
            if (xfer) begin
               state_d = ST_SYNC;
               fr_d    = {SYNC_WORD[6:0], pay};
               q_d     = SYNC_WORD[7];
               grant_d = gnt[1];
               ptr_d   = ~gnt[1];
`ifdef CMI_TX_PARITY_EN
               par_d   = ^pay;
`endif
            end
         end
         ST_SYNC: begin
            if (cnt_q == SYNC_LAST) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            done_d = cnt_q == DONE_AT;
            if (cnt_q == DATA_LAST) begin
               cnt_d = '0;
`ifdef CMI_TX_PARITY_EN
               state_d = ST_PARITY;
               q_d     = par_q;
`else
               state_d = ST_IDLE;
               q_d     = 1'b0;
`endif
            end
         end
`ifdef CMI_TX_PARITY_EN
         ST_PARITY: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fr_q    <= '0;
         q_q     <= 1'b0;
         done_q  <= 1'b0;
         grant_q <= 1'b0;
         ptr_q   <= 1'b0;
`ifdef CMI_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fr_q    <= fr_d;
         q_q     <= q_d;
         done_q  <= done_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
`ifdef CMI_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_cmi_tx_ctrl.sv
// tb_cmi_tx_ctrl: scoreboard bench for cmi_tx_ctrl; expected frames queued at accept, checked at frame_done.
module tb_cmi_tx_ctrl;
`ifdef CMI_TX_PARITY_EN
   localparam int FL     = 17;
`else
   localparam int FL     = 16;
`endif
   localparam int DONE_K = FL;
   logic       clk_sig = 1'b0;
   logic       reset_sig = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [7:0] req_data0 = 8'h00;
   logic [7:0] req_data1 = 8'h00;
   logic [1:0] req_ready;
   logic       q_sig, enc_reset_sig, busy, grant_id, frame_done;
   typedef struct {
      logic [FL-1:0] bits;
      logic          gid;
   } exp_t;
   exp_t sb[$];
   int   pass_n = 0;
   int   total_n = 0;
   cmi_tx_ctrl dut (
      .clk_sig      (clk_sig),
      .reset_sig    (reset_sig),
      .req_valid    (req_valid),
      .req_data0    (req_data0),
      .req_data1    (req_data1),
      .req_ready    (req_ready),
      .q_sig        (q_sig),
      .enc_reset_sig(enc_reset_sig),
      .busy         (busy),
      .grant_id     (grant_id),
      .frame_done   (frame_done)
   );
   always #5 clk_sig = ~clk_sig;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask
   function automatic logic [FL-1:0] frame(input logic [7:0] d);
`ifdef CMI_TX_PARITY_EN
      return {8'hE4, d, ^d};
`else
      return {8'hE4, d};
`endif
   endfunction
   task automatic offer(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] er, input bit push, input string nm);
      req_valid = v;
      req_data0 = d0;
      req_data1 = d1;
      #1;
      chk(nm, req_ready, er);
      if (push && er != 2'b00) sb.push_back('{frame(er[1] ? d1 : d0), er[1]});
   endtask
   task automatic wait_idle();
      int b = 0;
      while (busy && b < 100) begin
         @(negedge clk_sig);
         b++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask
   logic [31:0] coll = '0;
   int          n = 0;
   logic        prev_done = 1'b0;
   exp_t        e;
   always @(negedge clk_sig) begin
      if (!reset_sig) begin
         n = 0;
         coll = '0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("gap_idle", busy, 0);
         chk("enc_rst_vs_busy", enc_reset_sig, busy);
         if (busy) begin
            chk("ready_in_frame", req_ready, 0);
            coll = {coll[30:0], q_sig};
            n++;
         end else chk("q_idle", q_sig, 0);
         if (frame_done) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("frame_len", n, FL);
               chk("frame_bits", coll[FL-1:0], e.bits);
               chk("grant_id", grant_id, e.gid);
            end
            n = 0;
            coll = '0;
         end
         prev_done = frame_done;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      int   k;
      logic flag;
      logic [31:0] pr;
      req_valid = 2'b11;
      repeat (3) @(negedge clk_sig);
      #1;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_q", q_sig, 0);
      chk("rst_enc", enc_reset_sig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_done", frame_done, 0);
      req_valid = 2'b00;
      @(negedge clk_sig);
      reset_sig = 1'b1;
      @(negedge clk_sig);
      offer(2'b01, 8'hA5, 8'h00, 2'b01, 1, "acc_a5");
      @(negedge clk_sig);
      chk("ready_after_acc", req_ready, 2'b00);
      req_valid = 2'b00;
      k = 1;
      while (!frame_done && k < 40) begin
         @(negedge clk_sig);
         k++;
      end
      chk("done_cycle", k, DONE_K);
      @(negedge clk_sig);
      wait_idle();
      offer(2'b01, 8'hA5, 8'h00, 2'b01, 1, "acc_hold");
      @(negedge clk_sig);
      req_valid = 2'b00;
      req_data0 = 8'h00;
      repeat (4) @(negedge clk_sig);
      req_data0 = 8'h5A;
      wait_idle();
      offer(2'b10, 8'h00, 8'h3C, 2'b10, 1, "acc_r1");
      @(negedge clk_sig);
      req_valid = 2'b00;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         offer(2'b11, 8'h0F, 8'hF0, (i % 2 == 1) ? 2'b10 : 2'b01, 1, "rr_alt");
         @(negedge clk_sig);
      end
      req_valid = 2'b00;
      for (int r = 0; r < 2; r++) begin
         wait_idle();
         @(negedge clk_sig);
         chk("enc_rst_idle", enc_reset_sig, 0);
         offer(2'b01, 8'hFF, 8'h00, 2'b01, 1, "acc_ff");
         flag = 1'b0;
         pr = '0;
         for (int i = 0; i < 16; i++) begin
            @(negedge clk_sig);
            req_valid = 2'b00;
            pr = {pr[29:0], q_sig ? (flag ? 2'b00 : 2'b11) : 2'b01};
            flag = flag ^ q_sig;
         end
         chk("enc_pairs", pr, 32'hCD45CCCC);
      end
      wait_idle();
      offer(2'b10, 8'h00, 8'hA5, 2'b10, 0, "acc_abort");
      for (k = 1; k <= 12; k++) begin
         @(negedge clk_sig);
         req_valid = 2'b00;
      end
      chk("busy_pre_abort", busy, 1);
      reset_sig = 1'b0;
      #1;
      chk("abort_q", q_sig, 0);
      chk("abort_busy", busy, 0);
      chk("abort_enc", enc_reset_sig, 0);
      chk("abort_gid", grant_id, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_sig);
         chk("abort_no_done", frame_done, 0);
      end
      reset_sig = 1'b1;
      @(negedge clk_sig);
      offer(2'b11, 8'h0F, 8'hF0, 2'b01, 1, "rr_after_reset");
      @(negedge clk_sig);
      req_valid = 2'b00;
      wait_idle();
      repeat (3) @(negedge clk_sig);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
